// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - parametrised inter-stage pipeline register with handshake, flush and optional skid entry
module pipeline_stage_reg #(
  parameter int DBITS     = 32,
  parameter int NUM_DATA  = 3,
  parameter int CTRL_BITS = 4,
  parameter int SKID      = 0,
  parameter int CNT_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_BITS-1:0]      in_ctrl,
  input  logic [NUM_DATA*DBITS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_BITS-1:0]      out_ctrl,
  output logic [NUM_DATA*DBITS-1:0] out_data,
  output logic [CNT_BITS-1:0]       drop_count
);

  localparam int DW = NUM_DATA * DBITS;

  // Main (output-facing) entry
  logic                 r_main_valid;
  logic [CTRL_BITS-1:0] r_main_ctrl;
  logic [DW-1:0]        r_main_data;

  // Skid entry, only ever filled when SKID != 0
  logic                 r_skid_valid;
  logic [CTRL_BITS-1:0] r_skid_ctrl;
  logic [DW-1:0]        r_skid_data;

  // Registered ready used by the skid variant; always equals ~r_skid_valid
  logic                 r_in_ready;
  logic [CNT_BITS-1:0]  r_drop_count;

  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_main_free;
  logic                 w_skid_load;
  logic                 w_skid_next;
  logic [1:0]           w_drop_add;
  logic [CNT_BITS+1:0]  w_drop_sum;
  logic [CNT_BITS-1:0]  w_drop_next;

  // Upstream ready: combinational for the single register, registered for the skid variant
  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = reset_n & r_in_ready;
    end else begin
      in_ready = reset_n & (~r_main_valid | out_ready);
    end
  end

  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = r_main_valid & out_ready;
  // Main can take a new entry when it is empty or is handing its entry downstream now
  assign w_main_free = ~r_main_valid | w_out_xfer;
  // A new entry parks in the skid slot only when main is full and stalled
  assign w_skid_load = (SKID != 0) & w_in_xfer & ~w_main_free;

  // Next skid occupancy, shared by the skid register and the registered ready
  always_comb begin
    w_skid_next = r_skid_valid;
    if (flush) begin
      w_skid_next = 1'b0;
    end else if (w_skid_load) begin
      w_skid_next = 1'b1;
    end else if (w_main_free && r_skid_valid) begin
      w_skid_next = 1'b0;
    end
  end

  // Count every valid entry a flush throws away (main, skid, same-cycle input), saturating
  always_comb begin
    w_drop_add  = 2'(r_main_valid) + 2'(r_skid_valid) + 2'(w_in_xfer);
    w_drop_sum  = {2'b00, r_drop_count} + (CNT_BITS+2)'(w_drop_add);
    w_drop_next = w_drop_sum[CNT_BITS-1:0];
    if (w_drop_sum > {2'b00, {CNT_BITS{1'b1}}}) begin
      w_drop_next = {CNT_BITS{1'b1}};
    end
  end

  // Main entry: refill from skid first to keep FIFO order, otherwise from the input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= r_skid_ctrl;
        r_main_data  <= r_skid_data;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= in_ctrl;
        r_main_data  <= in_data;
      end else if (r_main_valid) begin
        // Bubble: control is zeroed so no write fires downstream, data is left as-is
        r_main_valid <= 1'b0;
        r_main_ctrl  <= '0;
      end
    end
  end

  // Skid entry and its registered ready copy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_skid_valid <= w_skid_next;
      r_in_ready   <= ~w_skid_next;
      if (w_skid_load) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  // Flush-drop statistics counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_drop_count <= '0;
    end else if (flush) begin
      r_drop_count <= w_drop_next;
    end
  end

  assign out_valid  = r_main_valid;
  assign out_ctrl   = r_main_ctrl;
  assign out_data   = r_main_data;
  assign drop_count = r_drop_count;

endmodule
